// File: rtl/csync_gen_pkg.sv
// rtl/csync_gen_pkg.sv - default 15 kHz timing, pattern encodings and colour constants for csync_timing_gen
package csync_gen_pkg;

  // Default Toaplan2-style timing, in VCLK cycles (horizontal) and lines (vertical)
  localparam logic [9:0] DEF_H_TOTAL     = 10'd432;
  localparam logic [9:0] DEF_H_SYNCLEN   = 10'd32;
  localparam logic [9:0] DEF_H_BACKPORCH = 10'd40;
  localparam logic [9:0] DEF_H_ACTIVE    = 10'd320;
  localparam logic [9:0] DEF_V_TOTAL     = 10'd262;
  localparam logic [9:0] DEF_V_SYNCLEN   = 10'd3;
  localparam logic [9:0] DEF_V_BACKPORCH = 10'd16;
  localparam logic [9:0] DEF_V_ACTIVE    = 10'd240;
  localparam logic [9:0] DEF_BAR_WIDTH   = 10'd40;

  // First active pixel / line for the default timing
  localparam logic [9:0] DEF_H_START = DEF_H_SYNCLEN + DEF_H_BACKPORCH;
  localparam logic [9:0] DEF_V_START = DEF_V_SYNCLEN + DEF_V_BACKPORCH;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_WHITE = 2'd3
  } pat_sel_e;

  localparam logic [4:0] COL_ON  = 5'h1F;
  localparam logic [4:0] COL_OFF = 5'h00;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb_t;

  // Bar index bits map straight onto the R/G/B channels (idx 7 = white)
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    c.r = idx[2] ? COL_ON : COL_OFF;
    c.g = idx[1] ? COL_ON : COL_OFF;
    c.b = idx[0] ? COL_ON : COL_OFF;
    return c;
  endfunction

endpackage

// File: rtl/csync_pattern_src.sv
// rtl/csync_pattern_src.sv - combinational test-pattern source (coordinates/bar index/select -> RGB)
module csync_pattern_src
  import csync_gen_pkg::*;
#(
  parameter logic [9:0] H_ACTIVE = DEF_H_ACTIVE,
  parameter logic [9:0] V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic       active,
  input  logic [8:0] xpos,
  input  logic [8:0] ypos,
  input  logic [2:0] bar_idx,
  input  pat_sel_e   sel,
  output logic [4:0] r,
  output logic [4:0] g,
  output logic [4:0] b
);

  rgb_t rgb;
  logic grid_hit;

  // Grid lines every 16 px/lines plus a closing line on the last active pixel and line
  always_comb begin
    grid_hit = (xpos[3:0] == 4'd0) || (ypos[3:0] == 4'd0) ||
               ({1'b0, xpos} == (H_ACTIVE - 10'd1)) ||
               ({1'b0, ypos} == (V_ACTIVE - 10'd1));
  end

  // Pattern select; everything is black outside the active area
  always_comb begin
    rgb = '0;
    if (active) begin
      case (sel)
        PAT_BARS:  rgb = bar_colour(bar_idx);
        PAT_GRID:  rgb = grid_hit ? '{r: COL_ON, g: COL_ON, b: COL_ON} : '0;
        PAT_WHITE: rgb = '{r: COL_ON, g: COL_ON, b: COL_ON};
        default:   rgb = '0;
      endcase
    end
  end

  assign r = rgb.r;
  assign g = rgb.g;
  assign b = rgb.b;

endmodule

// File: rtl/csync_timing_gen.sv
// rtl/csync_timing_gen.sv - 15 kHz composite-sync timing generator with RGB test patterns (option: CSYNC_SERRATION_EN)
module csync_timing_gen
  import csync_gen_pkg::*;
#(
  parameter logic [9:0] H_TOTAL     = DEF_H_TOTAL,
  parameter logic [9:0] H_SYNCLEN   = DEF_H_SYNCLEN,
  parameter logic [9:0] H_BACKPORCH = DEF_H_BACKPORCH,
  parameter logic [9:0] H_ACTIVE    = DEF_H_ACTIVE,
  parameter logic [9:0] V_TOTAL     = DEF_V_TOTAL,
  parameter logic [9:0] V_SYNCLEN   = DEF_V_SYNCLEN,
  parameter logic [9:0] V_BACKPORCH = DEF_V_BACKPORCH,
  parameter logic [9:0] V_ACTIVE    = DEF_V_ACTIVE,
  parameter logic [9:0] BAR_WIDTH   = DEF_BAR_WIDTH
) (
  input  logic       VCLK_i,
  input  logic       reset,
  input  logic       enable_i,
  input  logic [1:0] pattern_sel_i,
  output logic [4:0] R_o,
  output logic [4:0] G_o,
  output logic [4:0] B_o,
  output logic       CSYNC_o,
  output logic       HSYNC_o,
  output logic       VSYNC_o,
  output logic       DE_o,
  output logic [8:0] xpos_o,
  output logic [8:0] ypos_o,
  output logic       frame_change_o
);

  localparam logic [9:0] H_START = H_SYNCLEN + H_BACKPORCH;
  localparam logic [9:0] H_END   = H_START + H_ACTIVE;
  localparam logic [9:0] V_START = V_SYNCLEN + V_BACKPORCH;
  localparam logic [9:0] V_END   = V_START + V_ACTIVE;

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [9:0] bar_px;
  logic [2:0] bar_idx;
  pat_sel_e   pat_q;

  logic       h_act;
  logic       v_act;
  logic       active;
  logic       line_end;
  logic       frame_start;
  logic       hs_n;
  logic       vs_n;
  logic       cs_n;
  logic [8:0] xpos_c;
  logic [8:0] ypos_c;
  logic [4:0] r_c;
  logic [4:0] g_c;
  logic [4:0] b_c;

  // Decode of the current counter state; everything below is registered from this
  always_comb begin
    h_act       = (hcnt >= H_START) && (hcnt < H_END);
    v_act       = (vcnt >= V_START) && (vcnt < V_END);
    active      = h_act && v_act;
    line_end    = (hcnt == H_TOTAL - 10'd1);
    frame_start = (hcnt == 10'd0) && (vcnt == 10'd0);
    xpos_c      = active ? 9'(hcnt - H_START) : 9'd0;
    ypos_c      = active ? 9'(vcnt - V_START) : 9'd0;
    hs_n        = (hcnt >= H_SYNCLEN);
    vs_n        = (vcnt >= V_SYNCLEN);
`ifdef CSYNC_SERRATION_EN
    // Serrated vsync: CSYNC goes high during the hsync slot of every vsync line
    cs_n        = ~(hs_n ^ vs_n);
`else
    cs_n        = hs_n & vs_n;
`endif
  end

  // Pixel and line counters; enable low freezes them
  always_ff @(posedge VCLK_i) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (enable_i) begin
      if (line_end) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_TOTAL - 10'd1) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Running bar counter tracking the current pixel; cleared outside the active span of each line
  always_ff @(posedge VCLK_i) begin
    if (reset) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (enable_i) begin
      if (!h_act || line_end) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == BAR_WIDTH - 10'd1) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px  <= bar_px + 10'd1;
      end
    end
  end

  // Pattern selection only changes at frame start so a frame is never mixed
  always_ff @(posedge VCLK_i) begin
    if (reset) begin
      pat_q <= PAT_BLACK;
    end else if (enable_i && frame_start) begin
      pat_q <= pat_sel_e'(pattern_sel_i);
    end
  end

  csync_pattern_src #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern_src (
    .active  (active),
    .xpos    (xpos_c),
    .ypos    (ypos_c),
    .bar_idx (bar_idx),
    .sel     (pat_q),
    .r       (r_c),
    .g       (g_c),
    .b       (b_c)
  );

  // Output register: syncs, DE, coordinates and RGB all leave on the same edge
  always_ff @(posedge VCLK_i) begin
    if (reset) begin
      R_o            <= '0;
      G_o            <= '0;
      B_o            <= '0;
      CSYNC_o        <= 1'b1;
      HSYNC_o        <= 1'b1;
      VSYNC_o        <= 1'b1;
      DE_o           <= 1'b0;
      xpos_o         <= '0;
      ypos_o         <= '0;
      frame_change_o <= 1'b0;
    end else if (enable_i) begin
      R_o            <= r_c;
      G_o            <= g_c;
      B_o            <= b_c;
      CSYNC_o        <= cs_n;
      HSYNC_o        <= hs_n;
      VSYNC_o        <= vs_n;
      DE_o           <= active;
      xpos_o         <= xpos_c;
      ypos_o         <= ypos_c;
      frame_change_o <= frame_start;
    end
  end

  // Timing parameters must fit inside a line and a frame
  a_h_fit: assert property (@(posedge VCLK_i)
    ({1'b0, H_SYNCLEN} + {1'b0, H_BACKPORCH} + {1'b0, H_ACTIVE}) <= {1'b0, H_TOTAL});
  a_v_fit: assert property (@(posedge VCLK_i)
    ({1'b0, V_SYNCLEN} + {1'b0, V_BACKPORCH} + {1'b0, V_ACTIVE}) <= {1'b0, V_TOTAL});

endmodule

// File: tb/tb_csync_timing_gen.sv
// tb/tb_csync_timing_gen.sv - scoreboard bench for csync_timing_gen (small-timing instance plus default-timing instance)
module tb_csync_timing_gen;

  // Reduced timing so several full frames fit in a short run
  localparam int TH   = 48;
  localparam int TSL  = 4;
  localparam int TBP  = 6;
  localparam int TA   = 32;
  localparam int TV   = 40;
  localparam int TVS  = 3;
  localparam int TVBP = 4;
  localparam int TVA  = 32;
  localparam int TBW  = 4;
  localparam int HS0  = TSL + TBP;
  localparam int VS0  = TVS + TVBP;

  // {R,G,B,CSYNC,HSYNC,VSYNC,DE,xpos,ypos,frame_change}
  localparam logic [37:0] RST_VEC = {15'd0, 3'b111, 1'b0, 9'd0, 9'd0, 1'b0};

  logic       VCLK_i = 1'b0;
  logic       reset;
  logic       enable_i;
  logic [1:0] pattern_sel_i;
  logic [4:0] R_o, G_o, B_o;
  logic       CSYNC_o, HSYNC_o, VSYNC_o, DE_o, frame_change_o;
  logic [8:0] xpos_o, ypos_o;

  logic       d_reset;
  logic       d_en;
  logic [1:0] d_sel;
  logic [4:0] d_r, d_g, d_b;
  logic       d_cs, d_hs, d_vs, d_de, d_fc;
  logic [8:0] d_x, d_y;

  int n_vec = 0;
  int n_err = 0;

  int          mh, mv;
  logic [1:0]  mpat;
  logic [37:0] last_exp;
  logic [37:0] sb_q[$];

  always #5 VCLK_i = ~VCLK_i;

  csync_timing_gen #(
    .H_TOTAL(10'(TH)), .H_SYNCLEN(10'(TSL)), .H_BACKPORCH(10'(TBP)), .H_ACTIVE(10'(TA)),
    .V_TOTAL(10'(TV)), .V_SYNCLEN(10'(TVS)), .V_BACKPORCH(10'(TVBP)), .V_ACTIVE(10'(TVA)),
    .BAR_WIDTH(10'(TBW))
  ) dut (
    .VCLK_i(VCLK_i), .reset(reset), .enable_i(enable_i), .pattern_sel_i(pattern_sel_i),
    .R_o(R_o), .G_o(G_o), .B_o(B_o), .CSYNC_o(CSYNC_o), .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o),
    .DE_o(DE_o), .xpos_o(xpos_o), .ypos_o(ypos_o), .frame_change_o(frame_change_o)
  );

  csync_timing_gen dut_def (
    .VCLK_i(VCLK_i), .reset(d_reset), .enable_i(d_en), .pattern_sel_i(d_sel),
    .R_o(d_r), .G_o(d_g), .B_o(d_b), .CSYNC_o(d_cs), .HSYNC_o(d_hs), .VSYNC_o(d_vs),
    .DE_o(d_de), .xpos_o(d_x), .ypos_o(d_y), .frame_change_o(d_fc)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Reference outputs for a given counter state, straight from the timing description
  function automatic logic [37:0] model_out(input int h, input int v, input logic [1:0] p);
    logic hs, vs, cs, de, fc;
    int x, y, idx;
    logic [4:0] r, g, b;
    hs = !(h < TSL);
    vs = !(v < TVS);
`ifdef CSYNC_SERRATION_EN
    cs = ~(hs ^ vs);
`else
    cs = hs & vs;
`endif
    de = (h >= HS0) && (h < HS0 + TA) && (v >= VS0) && (v < VS0 + TVA);
    x = de ? h - HS0 : 0;
    y = de ? v - VS0 : 0;
    r = 5'd0; g = 5'd0; b = 5'd0;
    if (de) begin
      case (p)
        2'd1: begin
          idx = x / TBW;
          r = idx[2] ? 5'h1F : 5'h00;
          g = idx[1] ? 5'h1F : 5'h00;
          b = idx[0] ? 5'h1F : 5'h00;
        end
        2'd2: begin
          if ((x % 16) == 0 || (y % 16) == 0 || x == TA - 1 || y == TVA - 1) begin
            r = 5'h1F; g = 5'h1F; b = 5'h1F;
          end
        end
        2'd3: begin r = 5'h1F; g = 5'h1F; b = 5'h1F; end
        default: ;
      endcase
    end
    fc = (h == 0) && (v == 0);
    return {r, g, b, cs, hs, vs, de, x[8:0], y[8:0], fc};
  endfunction

  // One clock: drive inputs, push the expected output, then pop and compare after the edge
  task automatic step(input logic rst, input logic en, input logic [1:0] sel);
    logic [37:0] exp, got;
    reset = rst;
    enable_i = en;
    pattern_sel_i = sel;
    if (rst) begin
      exp = RST_VEC;
      mh = 0; mv = 0; mpat = 2'd0;
    end else if (en) begin
      exp = model_out(mh, mv, mpat);
      if (mh == 0 && mv == 0) mpat = sel;
      mh++;
      if (mh == TH) begin
        mh = 0;
        mv++;
        if (mv == TV) mv = 0;
      end
    end else begin
      exp = last_exp;
    end
    last_exp = exp;
    sb_q.push_back(exp);
    @(posedge VCLK_i);
    #1;
    got = {R_o, G_o, B_o, CSYNC_o, HSYNC_o, VSYNC_o, DE_o, xpos_o, ypos_o, frame_change_o};
    if (sb_q.size() == 0) check_eq("sb_empty", 64'd1, 64'd0);
    else check_eq("sb", 64'(got), 64'(sb_q.pop_front()));
  endtask

  task automatic run_to(input int h, input int v, input logic [1:0] sel);
    for (int i = 0; i < TH * TV + 1 && !(mh == h && mv == v); i++) step(1'b0, 1'b1, sel);
  endtask

  initial begin
    int hs_low0, hs_falls, vs_low, cs_low, de_cnt, first_de, last_x, first_y;
    logic prev_hs;
    reset = 1'b1; enable_i = 1'b0; pattern_sel_i = 2'd0;
    d_reset = 1'b1; d_en = 1'b1; d_sel = 2'd0;
    mh = 0; mv = 0; mpat = 2'd0; last_exp = RST_VEC;
    #1;

    // Reset, then first frame of colour bars
    repeat (5) step(1'b1, 1'b1, 2'd1);
    repeat (TH * TV) step(1'b0, 1'b1, 2'd1);
    // Switch to white mid-frame; bars continue to frame end, then white
    run_to(0, VS0 + 10, 2'd1);
    run_to(0, 0, 2'd3);
    repeat (TH * TV) step(1'b0, 1'b1, 2'd3);
    // Grid frame
    repeat (TH * TV) step(1'b0, 1'b1, 2'd2);
    // Freeze mid-line for 50 cycles, then resume
    run_to(20, VS0 + 3, 2'd2);
    repeat (50) step(1'b0, 1'b0, 2'd2);
    repeat (TH * 2) step(1'b0, 1'b1, 2'd2);
    // Random enable and select churn
    repeat (600) step(1'b0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
    // Mid-frame reset, then a full frame from a clean start
    repeat (2) step(1'b1, 1'b1, 2'd1);
    repeat (TH * TV + 10) step(1'b0, 1'b1, 2'd1);

    // Default-timing instance: measure the first 20 lines after reset release
    check_eq("def_reset_state", 64'({d_hs, d_vs, d_cs, d_de, d_fc, d_r, d_x}), 64'({5'b11100, 5'd0, 9'd0}));
    d_reset = 1'b0;
    hs_low0 = 0; hs_falls = 0; vs_low = 0; cs_low = 0; de_cnt = 0;
    first_de = -1; last_x = -1; first_y = -1; prev_hs = 1'b1;
    for (int i = 0; i < 20 * 432; i++) begin
      @(posedge VCLK_i);
      #1;
      if (i == 0) check_eq("def_fc_first", 64'(d_fc), 64'd1);
      if (i == 1) check_eq("def_fc_second", 64'(d_fc), 64'd0);
      if (!d_hs && i < 432) hs_low0++;
      if (prev_hs && !d_hs) hs_falls++;
      prev_hs = d_hs;
      if (!d_vs) vs_low++;
      if (!d_cs) cs_low++;
      if (d_de) begin
        if (first_de < 0) begin
          first_de = i;
          first_y = int'(d_y);
        end
        de_cnt++;
        last_x = int'(d_x);
      end
    end
    check_eq("def_hsync_low", 64'(hs_low0), 64'd32);
    check_eq("def_hsync_periods", 64'(hs_falls), 64'd20);
    check_eq("def_vsync_low", 64'(vs_low), 64'd1296);
`ifdef CSYNC_SERRATION_EN
    check_eq("def_csync_low", 64'(cs_low), 64'(3 * 400 + 17 * 32));
`else
    check_eq("def_csync_low", 64'(cs_low), 64'(3 * 432 + 17 * 32));
`endif
    check_eq("def_de_count", 64'(de_cnt), 64'd320);
    check_eq("def_first_de", 64'(first_de), 64'(19 * 432 + 72));
    check_eq("def_first_ypos", 64'(first_y), 64'd0);
    check_eq("def_last_xpos", 64'(last_x), 64'd319);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
